// File: rtl/multi_dice_roller_if.sv
// Button-in / result-out bundle for multi_dice_roller.
// The button source is the master; the roller is the slave.
interface multi_dice_roller_if #(
  parameter int NUM_DICE = 2,
  parameter int SIDES    = 6
);
  localparam int FW = $clog2(SIDES + 1);
  localparam int SW = $clog2(NUM_DICE * SIDES + 1);

  logic                   btn;
  logic [NUM_DICE*FW-1:0] faces;
  logic [SW-1:0]          sum;
  logic                   choose;
  logic                   doubles;
  logic                   done;
  logic [7:0]             roll_count;

  modport master (
    output btn,
    input  faces, sum, choose, doubles, done, roll_count
  );

  modport slave (
    input  btn,
    output faces, sum, choose, doubles, done, roll_count
  );
endinterface

// File: rtl/multi_dice_roller.sv
// NUM_DICE x SIDES odometer dice roller: rolls while the button is held, holds the result on release.
// Define MULTI_DICE_ROLLER_DEBOUNCE_EN to insert a 2-flop synchroniser plus DB_CYCLES debouncer on btn.
module multi_dice_roller #(
  parameter int NUM_DICE  = 2,
  parameter int SIDES     = 6,
  parameter int DB_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  multi_dice_roller_if.slave    dice_if
);
  localparam int FW = $clog2(SIDES + 1);
  localparam int SW = $clog2(NUM_DICE * SIDES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLED = 2'd2
  } state_t;

  state_t        state_q;
  logic [FW-1:0] face_q      [NUM_DICE];
  logic [FW-1:0] face_inc_d  [NUM_DICE];
  logic [NUM_DICE-1:0] carry_d;
  logic          done_q;
  logic [7:0]    count_q;
  logic          btn_int;
  logic [SW-1:0] sum_d;
  logic          all_eq_d;

`ifdef MULTI_DICE_ROLLER_DEBOUNCE_EN
  logic       sync1_q, sync2_q, btn_db_q;
  logic [7:0] db_cnt_q;

  // btn_db_q flips only after DB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= 8'd0;
    end else begin
      sync1_q <= dice_if.btn;
      sync2_q <= sync1_q;
      if (sync2_q != btn_db_q) begin
        if (db_cnt_q == 8'(DB_CYCLES - 1)) begin
          btn_db_q <= sync2_q;
          db_cnt_q <= 8'd0;
        end else begin
          db_cnt_q <= db_cnt_q + 8'd1;
        end
      end else begin
        db_cnt_q <= 8'd0;
      end
    end
  end

  assign btn_int = btn_db_q;
`else
  assign btn_int = dice_if.btn;
`endif

  assign carry_d[0] = 1'b1;

  // Die gi steps only when every lower die sits at SIDES
  for (genvar gi = 0; gi < NUM_DICE; gi++) begin : g_die
    if (gi < NUM_DICE - 1) begin : g_carry
      assign carry_d[gi+1] = carry_d[gi] & (face_q[gi] == FW'(SIDES));
    end
    assign face_inc_d[gi] = !carry_d[gi]                ? face_q[gi] :
                            (face_q[gi] == FW'(SIDES))  ? FW'(1)     :
                                                          face_q[gi] + FW'(1);
    assign dice_if.faces[gi*FW +: FW] = face_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      count_q <= 8'd0;
      for (int i = 0; i < NUM_DICE; i++) face_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_int) begin
            state_q <= ROLLING;
            for (int i = 0; i < NUM_DICE; i++) face_q[i] <= FW'(1);
          end
        end
        ROLLING: begin
          if (btn_int) begin
            face_q <= face_inc_d;
          end else begin
            state_q <= SETTLED;
            done_q  <= 1'b1;
            if (count_q != 8'hFF) count_q <= count_q + 8'd1;
          end
        end
        SETTLED: begin
          if (btn_int) begin
            state_q <= ROLLING;
            face_q  <= face_inc_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_DICE; i++) sum_d = sum_d + SW'(face_q[i]);
  end

  always_comb begin
    all_eq_d = 1'b1;
    for (int i = 1; i < NUM_DICE; i++) begin
      if (face_q[i] != face_q[0]) all_eq_d = 1'b0;
    end
  end

  assign dice_if.sum        = sum_d;
  assign dice_if.choose     = (state_q == SETTLED);
  assign dice_if.doubles    = (NUM_DICE >= 2) && (state_q == SETTLED) && all_eq_d;
  assign dice_if.done       = done_q;
  assign dice_if.roll_count = count_q;
endmodule

// File: tb/tb_multi_dice_roller.sv
// Self-checking bench for multi_dice_roller (NUM_DICE=2, SIDES=6, default build).
// Uses vector table, hand sequences and randomized presses against a positional-number reference model.
module tb_multi_dice_roller;
  localparam int ND   = 2;
  localparam int S    = 6;
  localparam int FW   = 3;
  localparam int NPOS = S * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_dice_roller_if #(.NUM_DICE(ND), .SIDES(S)) dif ();

  multi_dice_roller #(.NUM_DICE(ND), .SIDES(S), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .dice_if (dif)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the dice read as a base-SIDES number m_pos, die 0 least significant
  int m_state;  // 0 idle, 1 rolling, 2 settled
  int m_pos;
  int m_done;
  int m_count;

  function automatic int m_face(input int i);
    int d;
    if (m_state == 0) return 0;
    d = m_pos;
    for (int k = 0; k < i; k++) d = d / S;
    return (d % S) + 1;
  endfunction

  function automatic int dut_face(input int i);
    return int'(dif.faces[i*FW +: FW]);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input bit b, input bit r);
    dif.btn = b;
    rst     = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_state = 0; m_pos = 0; m_done = 0; m_count = 0;
    end else begin
      m_done = 0;
      case (m_state)
        0: if (b) begin m_state = 1; m_pos = 0; end
        1: if (b) m_pos = (m_pos + 1) % NPOS;
           else begin
             m_state = 2; m_done = 1;
             if (m_count < 255) m_count++;
           end
        default: if (b) begin m_state = 1; m_pos = (m_pos + 1) % NPOS; end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    int s;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      check($sformatf("%s face%0d", tag, i), dut_face(i), m_face(i));
      s += m_face(i);
    end
    check({tag, " sum"},     int'(dif.sum),        s);
    check({tag, " choose"},  int'(dif.choose),     int'(m_state == 2));
    check({tag, " doubles"}, int'(dif.doubles),    int'(m_state == 2 && m_face(0) == m_face(1)));
    check({tag, " done"},    int'(dif.done),       m_done);
    check({tag, " count"},   int'(dif.roll_count), m_count);
  endtask

  typedef struct {
    int press;
    int d0;
    int d1;
    int sm;
    int dbl;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{press: 1,  d0: 1, d1: 1, sm: 2,  dbl: 1};
    vecs[1] = '{press: 7,  d0: 1, d1: 2, sm: 3,  dbl: 0};
    vecs[2] = '{press: 37, d0: 1, d1: 1, sm: 2,  dbl: 1};
    vecs[3] = '{press: 2,  d0: 2, d1: 1, sm: 3,  dbl: 0};
    vecs[4] = '{press: 12, d0: 6, d1: 2, sm: 8,  dbl: 0};
    vecs[5] = '{press: 36, d0: 6, d1: 6, sm: 12, dbl: 1};
    vecs[6] = '{press: 8,  d0: 2, d1: 2, sm: 4,  dbl: 1};

    dif.btn = 1'b0;
    rst     = 1'b1;
    m_state = 0; m_pos = 0; m_done = 0; m_count = 0;

    // Reset state, then idle with button released
    tick(0, 1);
    check("reset faces", int'(dif.faces), 0);
    check("reset sum", int'(dif.sum), 0);
    check("reset choose", int'(dif.choose), 0);
    check("reset doubles", int'(dif.doubles), 0);
    check("reset done", int'(dif.done), 0);
    check("reset count", int'(dif.roll_count), 0);
    for (int c = 0; c < 10; c++) begin
      tick(0, 0);
      check("idle faces", int'(dif.faces), 0);
      check("idle choose", int'(dif.choose), 0);
    end
    $display("idle: 10 cycles with btn=0");

    // Table: from IDLE press N edges, release, then one held cycle
    for (int v = 0; v < 7; v++) begin
      tick(0, 1);
      for (int p = 0; p < vecs[v].press; p++) tick(1, 0);
      tick(0, 0);
      check($sformatf("vec%0d die0", v), dut_face(0), vecs[v].d0);
      check($sformatf("vec%0d die1", v), dut_face(1), vecs[v].d1);
      check($sformatf("vec%0d sum", v), int'(dif.sum), vecs[v].sm);
      check($sformatf("vec%0d doubles", v), int'(dif.doubles), vecs[v].dbl);
      check($sformatf("vec%0d choose", v), int'(dif.choose), 1);
      check($sformatf("vec%0d done", v), int'(dif.done), 1);
      check($sformatf("vec%0d count", v), int'(dif.roll_count), 1);
      tick(0, 0);
      check($sformatf("vec%0d done2", v), int'(dif.done), 0);
      check($sformatf("vec%0d hold sum", v), int'(dif.sum), vecs[v].sm);
      $display("vec%0d: press=%0d faces={%0d,%0d} sum=%0d doubles=%0d",
               v, vecs[v].press, dut_face(0), dut_face(1), dif.sum, dif.doubles);
    end

    // Continue from a settled result without reload
    tick(0, 1);
    for (int p = 0; p < 7; p++) tick(1, 0);
    tick(0, 0);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    check("cont die0", dut_face(0), 3);
    check("cont die1", dut_face(1), 2);
    check("cont sum", int'(dif.sum), 5);
    check("cont count", int'(dif.roll_count), 2);
    $display("continue: faces={%0d,%0d} sum=%0d count=%0d", dut_face(0), dut_face(1), dif.sum, dif.roll_count);

    // Reset mid-roll with btn held
    tick(1, 0);
    tick(1, 0);
    tick(1, 1);
    check("midrst faces", int'(dif.faces), 0);
    check("midrst choose", int'(dif.choose), 0);
    check("midrst count", int'(dif.roll_count), 0);
    tick(1, 0);
    check("postrst die0", dut_face(0), 1);
    check("postrst die1", dut_face(1), 1);
    check("postrst sum", int'(dif.sum), 2);
    tick(0, 0);
    $display("midroll reset: reloaded faces={%0d,%0d}", dut_face(0), dut_face(1));

    // Roll counter saturation
    tick(0, 1);
    for (int r = 1; r <= 260; r++) begin
      tick(1, 0);
      tick(0, 0);
      check($sformatf("sat%0d done", r), int'(dif.done), 1);
      check($sformatf("sat%0d count", r), int'(dif.roll_count), (r > 255) ? 255 : r);
      tick(0, 0);
      check($sformatf("sat%0d done2", r), int'(dif.done), 0);
    end
    $display("saturation: 260 rolls, count=%0d", dif.roll_count);

    // Randomized presses with occasional resets, checked every edge
    tick(0, 1);
    for (int n = 0; n < 80; n++) begin
      int hold, gap;
      hold = $urandom_range(1, 40);
      gap  = $urandom_range(1, 4);
      for (int h = 0; h < hold; h++) begin
        tick(1, ($urandom_range(0, 199) == 0));
        check_model($sformatf("rnd%0d hold", n));
      end
      for (int g = 0; g < gap; g++) begin
        tick(0, ($urandom_range(0, 29) == 0));
        check_model($sformatf("rnd%0d gap", n));
      end
      $display("rnd%0d: hold=%0d gap=%0d faces={%0d,%0d} count=%0d",
               n, hold, gap, dut_face(0), dut_face(1), dif.roll_count);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
